// File: rtl/proc_phase_ctrl.sv
// proc_phase_ctrl: multicycle IF/ID/EX/MEM/WB sequencer driving stall/pc_rst for proc_top.
// Define PHASE_PERF_CNT_EN to add the cyc_cnt/instr_cnt performance counters.
module proc_phase_ctrl #(
  parameter logic [31:0] HALT_PC      = 32'h80088008,
  parameter int unsigned PC_RST_CYC   = 2,
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        jbr_taken,
  input  logic        mem_ready,
  output logic        stall,
  output logic        pc_rst,
  output logic [2:0]  phase,
  output logic        mem_req,
  output logic        instr_done,
  output logic        halted,
  output logic        timeout_err
`ifdef PHASE_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);
  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_PCRST = 3'd5,
    S_HALT  = 3'd6,
    S_ERR   = 3'd7
  } state_t;
  localparam logic [3:0] RST_LAST  = 4'(PC_RST_CYC);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
  state_t     state_q, state_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       stall_q, pc_rst_q, mem_req_q, instr_done_q, halted_q, timeout_err_q;
  logic       stall_d, pc_rst_d, mem_req_d, instr_done_d, halted_d, timeout_err_d;
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_PCRST: begin
        state_d   = (rst_cnt_q == RST_LAST) ? S_IF : S_PCRST;
        rst_cnt_d = (rst_cnt_q == RST_LAST) ? rst_cnt_q : rst_cnt_q + 4'd1;
      end
      S_IF: state_d = S_ID;
      S_ID: state_d = jbr_taken ? S_WB : S_EX;
      S_EX: begin
        state_d    = jbr_taken ? S_WB : S_MEM;
        wait_cnt_d = '0;
      end
      // a late mem_ready on the final allowed cycle still completes the access
      S_MEM: begin
        state_d    = mem_ready ? S_WB : (wait_cnt_q == WAIT_LAST) ? S_ERR : S_MEM;
        wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 8'd1;
      end
      S_WB: state_d = (next_pc == HALT_PC) ? S_HALT : S_IF;
      default: state_d = state_q;
    endcase
    stall_d       = state_d != S_WB;
    pc_rst_d      = state_d == S_PCRST;
    mem_req_d     = state_d == S_MEM;
    instr_done_d  = state_d == S_WB;
    halted_d      = state_d == S_HALT;
    timeout_err_d = state_d == S_ERR;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_PCRST;
      rst_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      stall_q       <= 1'b0;
      pc_rst_q      <= 1'b1;
      mem_req_q     <= 1'b0;
      instr_done_q  <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_q       <= stall_d;
      pc_rst_q      <= pc_rst_d;
      mem_req_q     <= mem_req_d;
      instr_done_q  <= instr_done_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign phase       = state_q;
  assign stall       = stall_q;
  assign pc_rst      = pc_rst_q;
  assign mem_req     = mem_req_q;
  assign instr_done  = instr_done_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
`ifdef PHASE_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, instr_cnt_q, instr_cnt_d;
  always_comb begin
    cyc_cnt_d   = (state_q inside {S_PCRST, S_HALT, S_ERR}) ? cyc_cnt_q : cyc_cnt_q + 32'd1;
    instr_cnt_d = instr_done_q ? instr_cnt_q + 32'd1 : instr_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end
  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif
endmodule

// File: tb/tb_proc_phase_ctrl.sv
// tb_proc_phase_ctrl: randomized bench; expected phases come from a per-instruction phase-trace model.
module tb_proc_phase_ctrl;
  localparam logic [31:0] HALT = 32'h80088008;
  localparam int RC = 2;
  localparam int MW = 8;
  localparam logic [8:0] RST_OUT = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jbr_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] next_pc = '0;
  logic        stall, pc_rst, mem_req, instr_done, halted, timeout_err;
  logic [2:0]  phase;
  logic [8:0]  obs;
`ifdef PHASE_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif
  int errs = 0, checks = 0, exp_cyc = 0, exp_instr = 0;
  int done_seen = 0, stall_low_seen = 0, mem_req_seen = 0;
  bit force_noise = 1'b0;

  proc_phase_ctrl #(.HALT_PC(HALT), .PC_RST_CYC(RC), .MEM_WAIT_MAX(MW)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .jbr_taken(jbr_taken), .mem_ready(mem_ready),
    .stall(stall), .pc_rst(pc_rst), .phase(phase), .mem_req(mem_req),
    .instr_done(instr_done), .halted(halted), .timeout_err(timeout_err)
`ifdef PHASE_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  assign obs = {phase, stall, pc_rst, mem_req, instr_done, halted, timeout_err};

  always #5 clk = ~clk;

  // independent pulse counters, sampled late in each cycle
  always @(negedge clk) begin
    #2;
    if (instr_done === 1'b1) done_seen++;
    if (stall === 1'b0) stall_low_seen++;
    if (mem_req === 1'b1) mem_req_seen++;
  end

  function automatic logic [8:0] exp_out(input int p);
    return {3'(p), p != 4, p == 5, p == 3, p == 4, p == 6, p == 7};
  endfunction

  task automatic drive_noise();
    jbr_taken = force_noise | 1'($urandom);
    mem_ready = 1'($urandom);
    next_pc   = ($urandom % 4 == 0) ? HALT : $urandom;
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== RST_OUT) begin
        errs++;
        $display("FAIL reset: outputs=%b expected=%b", obs, RST_OUT);
      end
`ifdef PHASE_PERF_CNT_EN
      checks++;
      if (cyc_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
        errs++;
        $display("FAIL reset_perf: cyc_cnt=%0d instr_cnt=%0d expected 0/0", cyc_cnt, instr_cnt);
      end
`endif
      drive_noise();
    end
    rst = 1'b1;
    exp_cyc = 0;
    exp_instr = 0;
  endtask

  task automatic pcrst();
    for (int i = 0; i < RC; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(5)) begin
        errs++;
        $display("FAIL pcrst cyc=%0d: outputs=%b expected=%b", i, obs, exp_out(5));
      end
      drive_noise();
    end
  endtask

  // Model: an instruction is the phase list IF,ID,[EX],[MEM x n],WB|ERR from the sequencing rules.
  task automatic run_instr(input int jb, input int d, input bit halt, input int stop = -1);
    int tr[$];
    int mj;
    int n;
    mj = 0;
    tr = {0, 1};
    if (jb == 1) tr.push_back(4);
    else begin
      tr.push_back(2);
      if (jb == 2) tr.push_back(4);
      else begin
        repeat (d < MW ? d + 1 : MW) tr.push_back(3);
        tr.push_back(d < MW ? 4 : 7);
      end
    end
    n = (stop < 0) ? tr.size() : stop;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(tr[k])) begin
        errs++;
        $display("FAIL instr jb=%0d d=%0d cyc=%0d: outputs=%b expected=%b", jb, d, k, obs, exp_out(tr[k]));
      end
`ifdef PHASE_PERF_CNT_EN
      checks++;
      if (cyc_cnt !== 32'(exp_cyc) || instr_cnt !== 32'(exp_instr)) begin
        errs++;
        $display("FAIL perf cyc=%0d: cyc_cnt=%0d instr_cnt=%0d expected %0d/%0d", k, cyc_cnt, instr_cnt, exp_cyc, exp_instr);
      end
      if (tr[k] < 5) exp_cyc++;
      if (tr[k] == 4) exp_instr++;
`endif
      drive_noise();
      if (tr[k] == 1) jbr_taken = (jb == 1);
      if (tr[k] == 2) jbr_taken = (jb == 2);
      if (tr[k] == 3) begin
        mem_ready = (mj == d);
        mj++;
      end
      if (tr[k] == 4) next_pc = halt ? HALT : ($urandom & 32'h7fffffff);
    end
  endtask

  task automatic test_reset();
    int l0;
    hold_reset(3);
    pcrst();
    l0 = stall_low_seen;
    run_instr(0, 0, 0);
    checks++;
    if (stall !== 1'b0 || stall_low_seen - l0 != 0) begin
      errs++;
      $display("FAIL first_stall_low: stall=%b early_lows=%0d expected stall=0 early_lows=0", stall, stall_low_seen - l0);
    end
  endtask

  task automatic test_straight();
    int d0, l0;
    #3;
    d0 = done_seen;
    l0 = stall_low_seen;
    repeat (4) run_instr(0, 0, 0);
    #3;
    checks++;
    if (done_seen - d0 != 4 || stall_low_seen - l0 != 4) begin
      errs++;
      $display("FAIL straight: done=%0d stall_low=%0d expected 4/4 in 20 cycles", done_seen - d0, stall_low_seen - l0);
    end
  endtask

  task automatic test_jbr();
    int d0;
    #3;
    d0 = done_seen;
    run_instr(1, 0, 0);
    run_instr(2, 0, 0);
    force_noise = 1'b1;
    run_instr(0, 2, 0);
    force_noise = 1'b0;
    #3;
    checks++;
    if (done_seen - d0 != 3) begin
      errs++;
      $display("FAIL jbr_done: done=%0d expected 3", done_seen - d0);
    end
  endtask

  task automatic test_mem_wait();
    int m0, l0;
    #3;
    m0 = mem_req_seen;
    run_instr(0, 3, 0);
    #3;
    checks++;
    if (mem_req_seen - m0 != 4) begin
      errs++;
      $display("FAIL mem_req_len: cycles=%0d expected 4", mem_req_seen - m0);
    end
    run_instr(0, MW - 1, 0);
    run_instr(0, MW, 0);
    #3;
    l0 = stall_low_seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(7)) begin
        errs++;
        $display("FAIL err_hold cyc=%0d: outputs=%b expected=%b", i, obs, exp_out(7));
      end
      drive_noise();
    end
    #3;
    checks++;
    if (stall_low_seen - l0 != 0) begin
      errs++;
      $display("FAIL err_stall: stall_low=%0d expected 0", stall_low_seen - l0);
    end
    hold_reset(1);
    pcrst();
  endtask

  task automatic test_halt();
    int l0;
    run_instr(0, 1, 1);
    #3;
    l0 = stall_low_seen;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(6)) begin
        errs++;
        $display("FAIL halt_hold cyc=%0d: outputs=%b expected=%b", i, obs, exp_out(6));
      end
      drive_noise();
    end
    #3;
    checks++;
    if (stall_low_seen - l0 != 0) begin
      errs++;
      $display("FAIL halt_stall: stall_low=%0d expected 0", stall_low_seen - l0);
    end
    hold_reset(2);
    pcrst();
    run_instr(0, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    int d0;
    run_instr(0, 5, 0, 5);
    hold_reset(1);
    pcrst();
    #3;
    d0 = done_seen;
    repeat (4) run_instr(0, int'($urandom % 3), 0);
    #3;
    checks++;
    if (done_seen - d0 != 4) begin
      errs++;
      $display("FAIL restart_done: done=%0d expected 4", done_seen - d0);
    end
`ifdef PHASE_PERF_CNT_EN
    @(posedge clk);
    #1;
    checks++;
    if (instr_cnt !== 32'd4) begin
      errs++;
      $display("FAIL instr_cnt: instr_cnt=%0d expected 4", instr_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int jb, d, d0, exp_wb;
    bit h;
    exp_wb = 0;
    #3;
    d0 = done_seen;
    for (int i = 0; i < 40; i++) begin
      jb = int'($urandom % 3);
      d  = ($urandom % 6 == 0) ? int'($urandom_range(MW, MW - 2)) : int'($urandom % 4);
      h  = ($urandom % 8 == 0);
      run_instr(jb, d, h);
      if (!(jb == 0 && d >= MW)) exp_wb++;
      if (h || (jb == 0 && d >= MW)) begin
        hold_reset(int'($urandom_range(3, 1)));
        pcrst();
      end
    end
    #3;
    checks++;
    if (done_seen - d0 != exp_wb) begin
      errs++;
      $display("FAIL random_done: done=%0d expected %0d", done_seen - d0, exp_wb);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_jbr();
    test_mem_wait();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/proc_phase_ctrl.md
Name: proc_phase_ctrl

Overview:
- Multicycle sequencer for the unpipelined MIPS `proc_top`.
- Drives `stall` and `pc_rst` so that one instruction walks through IF/ID/EX/MEM/WB, with one PC advance per instruction.
- Handles early branch/jump release, data-memory wait handshake, a halt sentinel PC and a memory-timeout error.
- Replaces ad-hoc stall counters in benches; sits beside `proc_top`, driven by the top-level clock/reset.

Parameters:
- HALT_PC, 32'h80088008, next_pc value that ends execution.
- PC_RST_CYC, 2, cycles pc_rst stays high after rst deasserts (1..15).
- MEM_WAIT_MAX, 8, max cycles in MEM waiting for mem_ready before error (1..255).

Ports:
- clk  in  1  processor clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- next_pc  in  32  next-PC value from proc_top
- jbr_taken  in  1  branch/jump resolved taken
- mem_ready  in  1  data memory completed access
- stall  out  1  high = hold PC/state in proc_top
- pc_rst  out  1  high = hold PC at reset vector
- phase  out  3  0=IF 1=ID 2=EX 3=MEM 4=WB 5=PCRST 6=HALT 7=ERR
- mem_req  out  1  high while in MEM phase
- instr_done  out  1  one-cycle pulse in WB
- halted  out  1  sticky, HALT reached
- timeout_err  out  1  sticky, MEM wait exceeded

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst sampled low at posedge clk resets the block.
- Outputs while in reset: stall=0, pc_rst=1, phase=5, mem_req=0, instr_done=0, halted=0, timeout_err=0. All counters are cleared.
- Reset mid-operation: a reset in any state returns to PCRST at that edge. Reset has priority over every other event.
- All outputs are registered from state (Moore). Inputs are sampled at posedge and affect the state one cycle later.
- PCRST: pc_rst=1, stall=1. Held for PC_RST_CYC cycles after the first edge with rst=1, then goes to IF with pc_rst=0.
- IF→ID→EX: one cycle each, stall=1.
- ID or EX with jbr_taken=1: next state is WB; the remaining phases are skipped.
- jbr_taken is ignored in IF, MEM, WB, HALT, ERR and PCRST.
- EX→MEM.
- MEM: mem_req=1, stall=1, wait counter increments per cycle.
  - mem_ready=1 → WB.
  - Counter reaches MEM_WAIT_MAX without mem_ready → ERR.
  - mem_ready in the same cycle the limit is reached: WB wins.
- WB: stall=0 (proc_top advances its PC on this edge), instr_done=1.
  - Next state is IF, unless next_pc==HALT_PC, in which case it is HALT.
  - The halt compare happens only in WB.
- HALT: stall=1, halted=1, mem_req=0. Held until reset.
- ERR: stall=1, timeout_err=1, mem_req=0. Held until reset.
- Nominal latency: 5 cycles per instruction plus memory wait. Taken jump/branch: 3 cycles if taken in ID, 4 cycles if taken in EX.
- Wait counter: 8 bits, saturating, cleared on MEM entry. PCRST counter: 4 bits.

Optional Feature:
- Macro: PHASE_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[31:0] and instr_cnt[31:0].
  - Both reset to 0; both wrap modulo 2^32.
  - cyc_cnt increments every cycle outside PCRST/HALT/ERR.
  - instr_cnt increments on each instr_done.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, PC_RST_CYC=2: rst low 3 cycles, then high → pc_rst=1 for 2 cycles, then phase=IF; first stall=0 in cycle 7 after release (2 PCRST + IF/ID/EX/MEM/WB), with mem_ready tied high.
- Straight-line code, mem_ready=1 always: 4 instructions → instr_done every 5 cycles; stall low exactly 1 cycle in 5.
- jbr_taken=1 in ID → phase goes 0,1,4; in EX → 0,1,2,4; jbr_taken in MEM has no effect.
- mem_ready delayed 3 cycles → MEM lasts 4 cycles, mem_req high throughout; mem_ready never with MEM_WAIT_MAX=8 → ERR after 8 MEM cycles, timeout_err=1, stall stuck at 1.
- next_pc=32'h80088008 during WB → phase=6, halted=1, no further stall=0; rst low → all outputs at reset values, then a normal restart.
- rst asserted during MEM wait → phase=5 at the next edge, mem_req=0; with PHASE_PERF_CNT_EN, instr_cnt equals instr_done pulses (e.g. 4) and cyc_cnt clears to 0 on reset.
